// File: rtl/jt89_att_sched_if.sv
// jt89_att_sched_if: sample/level bundle between the attenuation scheduler and its host (mute_i with JT89_ATT_MUTE_EN)
interface jt89_att_sched_if;
  logic        cen;
  logic [3:0]  bit_i;
  logic [15:0] vol_i;
`ifdef JT89_ATT_MUTE_EN
  logic [3:0]  mute_i;
`endif
  logic [8:0]  ch0;
  logic [8:0]  ch1;
  logic [8:0]  ch2;
  logic [8:0]  noise;
  logic        frame;
  logic        busy;
  logic        overrun;
`ifdef JT89_ATT_MUTE_EN
  modport master(output cen, bit_i, vol_i, mute_i, input ch0, ch1, ch2, noise, frame, busy, overrun);
  modport slave(input cen, bit_i, vol_i, mute_i, output ch0, ch1, ch2, noise, frame, busy, overrun);
`else
  modport master(output cen, bit_i, vol_i, input ch0, ch1, ch2, noise, frame, busy, overrun);
  modport slave(input cen, bit_i, vol_i, output ch0, ch1, ch2, noise, frame, busy, overrun);
`endif
endinterface

// File: rtl/jt89_att_sched.sv
// jt89_att_sched: one shared attenuation ROM swept over ch0/ch1/ch2/noise per cen (JT89_ATT_MUTE_EN adds mute_i)
module jt89_att_sched (
  input logic clk,
  input logic rst,
  jt89_att_sched_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, S0 = 3'd1, S1 = 3'd2, S2 = 3'd3, S3 = 3'd4, DONE = 3'd5;
  localparam logic [8:0] ROM [16] = '{9'd511, 9'd406, 9'd322, 9'd256, 9'd203, 9'd162, 9'd128, 9'd102,
                                      9'd81, 9'd64, 9'd51, 9'd41, 9'd32, 9'd26, 9'd20, 9'd0};
  logic [2:0] st;
  logic       pending;
  logic       pipe_vld;
  logic [1:0] pipe_idx;
  logic [8:0] pipe;
  logic [1:0] k;
  logic [3:0] vol_k;
  logic       on_k;
  logic       capture;
  always_comb begin
    k = 2'(st - S0);
    vol_k = bus.vol_i[k*4 +: 4];
`ifdef JT89_ATT_MUTE_EN
    on_k = bus.bit_i[k] & ~bus.mute_i[k];
`else
    on_k = bus.bit_i[k];
`endif
    capture = st != IDLE && st != DONE;
  end
  assign bus.busy = st != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      pending <= 1'b0;
      pipe_vld <= 1'b0;
      pipe_idx <= 2'd0;
      pipe <= 9'd0;
      bus.ch0 <= 9'd0;
      bus.ch1 <= 9'd0;
      bus.ch2 <= 9'd0;
      bus.noise <= 9'd0;
      bus.frame <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      st <= st == IDLE ? ((bus.cen || pending) ? S0 : IDLE) : st == DONE ? IDLE : st + 3'd1;
      // a cen during a sweep (DONE included) is queued once; a second one is dropped
      if (st == IDLE) pending <= 1'b0;
      else if (bus.cen && !pending) pending <= 1'b1;
      else if (bus.cen) bus.overrun <= 1'b1;
      pipe_vld <= capture;
      if (capture) begin
        pipe <= on_k ? ROM[vol_k] : 9'd0;
        pipe_idx <= k;
      end
      bus.ch0 <= (pipe_vld && pipe_idx == 2'd0) ? pipe : bus.ch0;
      bus.ch1 <= (pipe_vld && pipe_idx == 2'd1) ? pipe : bus.ch1;
      bus.ch2 <= (pipe_vld && pipe_idx == 2'd2) ? pipe : bus.ch2;
      bus.noise <= (pipe_vld && pipe_idx == 2'd3) ? pipe : bus.noise;
      bus.frame <= st == DONE;
    end
  end
endmodule
